// File: rtl/prbs_pkg.sv
// Shared definitions for the XNOR-feedback PRBS7 (x^7 + x^6 + 1) generator and checker.
package prbs_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int PRBS7_LEN = 7;
    localparam int TAP_A     = 6;
    localparam int TAP_B     = 5;

    localparam logic [PRBS7_LEN-1:0] PRBS7_ALL_ONES = '1;

    // XNOR feedback: the all-ones register is the lockup state, all-zeros is legal.
    function automatic logic prbs7_pred(input logic [PRBS7_LEN-1:0] s);
        return ~(s[TAP_A] ^ s[TAP_B]);
    endfunction

endpackage

// File: rtl/xnor_lfsr7.sv
// 7-bit XNOR LFSR, either seeded bit-by-bit from external data or free-running on its own prediction.
module xnor_lfsr7
    import prbs_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 load,
    input  logic                 din,
    output logic [PRBS7_LEN-1:0] lfsr,
    output logic                 pred
);

    assign pred = prbs7_pred(lfsr);

    // NOTE: registers are written with <= only, so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr <= '0;
        end else if (en) begin
            lfsr <= {lfsr[PRBS7_LEN-2:0], load ? din : pred};
        end
    end

endmodule

// File: rtl/prbs7_xnor_checker.sv
// Serial PRBS7 checker: self-seeds from the received stream in HUNT, free-runs in LOCKED and counts errors.
module prbs7_xnor_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_CNT = 16,
    parameter int LOSS_CNT = 4,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clr_err,
    output logic             match,
    output logic             match_valid,
    output logic             locked,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int FILL_W = 3;
    localparam int RUN_W  = 8;
    localparam int LOSS_W = 4;

    state_t              state_q, state_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [RUN_W-1:0]    run_q, run_d;
    logic [LOSS_W-1:0]   loss_q, loss_d;
    logic [ERR_W-1:0]    err_d;
    logic                match_d, match_valid_d;

    logic                lfsr_en, lfsr_load;
    logic [PRBS7_LEN-1:0] lfsr;
    logic                pred;
    logic                bit_ok;

    xnor_lfsr7 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (lfsr_en),
        .load  (lfsr_load),
        .din   (in_bit),
        .lfsr  (lfsr),
        .pred  (pred)
    );

    assign bit_ok = ~(pred ^ in_bit);

    // NOTE: every signal gets a default before any branch so no path leaves one unassigned (no latches).
    always_comb begin
        state_d       = state_q;
        fill_d        = fill_q;
        run_d         = run_q;
        loss_d        = loss_q;
        err_d         = err_cnt;
        match_d       = match;
        match_valid_d = 1'b0;
        lfsr_en       = in_valid;
        lfsr_load     = (state_q == HUNT);

        if (in_valid) begin
            if (state_q == HUNT) begin
                if (fill_q != FILL_W'(PRBS7_LEN)) begin
                    fill_d = fill_q + 1'b1;
                    run_d  = '0;
                end else begin
                    match_valid_d = 1'b1;
                    match_d       = bit_ok;
                    if (!bit_ok) begin
                        run_d = '0;
                    end else if (run_q == RUN_W'(LOCK_CNT - 1)) begin
                        // A stuck-at-1 stream matches forever in the lockup state; refuse to lock on it.
                        run_d = '0;
                        if (lfsr != PRBS7_ALL_ONES) begin
                            state_d = LOCKED;
                            loss_d  = '0;
                        end
                    end else begin
                        run_d = run_q + 1'b1;
                    end
                end
            end else begin
                match_valid_d = 1'b1;
                match_d       = bit_ok;
                if (bit_ok) begin
                    loss_d = '0;
                end else begin
                    if (err_cnt != '1) begin
                        err_d = err_cnt + 1'b1;
                    end
                    if (loss_q == LOSS_W'(LOSS_CNT - 1)) begin
                        state_d = HUNT;
                        fill_d  = '0;
                        run_d   = '0;
                        loss_d  = '0;
                    end else begin
                        loss_d = loss_q + 1'b1;
                    end
                end
            end
        end

        if (clr_err) begin
            err_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            fill_q      <= '0;
            run_q       <= '0;
            loss_q      <= '0;
            err_cnt     <= '0;
            match       <= 1'b0;
            match_valid <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            run_q       <= run_d;
            loss_q      <= loss_d;
            err_cnt     <= err_d;
            match       <= match_d;
            match_valid <= match_valid_d;
        end
    end

    assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_prbs7_xnor_checker.sv
// Directed and randomized bench for prbs7_xnor_checker against a bit-history reference model.
module tb_prbs7_xnor_checker;

    localparam int LOCK_CNT = 16;
    localparam int LOSS_CNT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_bit = 1'b0;
    logic        clr_err = 1'b0;

    logic        match_a, match_valid_a, locked_a;
    logic [15:0] err_a;
    logic        match_b, match_valid_b, locked_b;
    logic [3:0]  err_b;

    always #5 clk = ~clk;

    prbs7_xnor_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .clr_err(clr_err),
        .match(match_a), .match_valid(match_valid_a), .locked(locked_a), .err_cnt(err_a)
    );

    prbs7_xnor_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .clr_err(clr_err),
        .match(match_b), .match_valid(match_valid_b), .locked(locked_b), .err_cnt(err_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: hist holds the last 7 bits of the reference sequence, oldest first.
    bit   hist[$];
    bit   m_locked, m_match, m_mv;
    int   m_run, m_loss, m_err, m_err4;

    // Stimulus source: clean PRBS7 where s[n] = ~(s[n-7] ^ s[n-6]), zeros before the start.
    bit   gen_hist[$];

    function automatic bit gen_next();
        bit b;
        b = ~(gen_hist[0] ^ gen_hist[1]);
        gen_hist.push_back(b);
        void'(gen_hist.pop_front());
        return b;
    endfunction

    task automatic gen_reset();
        gen_hist.delete();
        for (int i = 0; i < 7; i++) gen_hist.push_back(1'b0);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_step(input bit rst, input bit v, input bit b, input bit c);
        bit p;
        bit all1;
        if (!rst) begin
            hist.delete();
            m_locked = 0; m_match = 0; m_mv = 0;
            m_run = 0; m_loss = 0; m_err = 0; m_err4 = 0;
            return;
        end
        m_mv = 0;
        if (v) begin
            if (!m_locked) begin
                if (hist.size() < 7) begin
                    hist.push_back(b);
                    m_run = 0;
                end else begin
                    p = ~(hist[0] ^ hist[1]);
                    all1 = 1;
                    foreach (hist[i]) all1 &= hist[i];
                    m_mv = 1;
                    m_match = (p == b);
                    if (!m_match) m_run = 0;
                    else if (m_run + 1 == LOCK_CNT) begin
                        m_run = 0;
                        if (!all1) begin
                            m_locked = 1;
                            m_loss = 0;
                        end
                    end else m_run++;
                    hist.push_back(b);
                    void'(hist.pop_front());
                end
            end else begin
                p = ~(hist[0] ^ hist[1]);
                m_mv = 1;
                m_match = (p == b);
                hist.push_back(p);
                void'(hist.pop_front());
                if (m_match) m_loss = 0;
                else begin
                    if (m_err < 65535) m_err++;
                    if (m_err4 < 15) m_err4++;
                    m_loss++;
                    if (m_loss == LOSS_CNT) begin
                        m_locked = 0;
                        hist.delete();
                        m_run = 0;
                        m_loss = 0;
                    end
                end
            end
        end
        if (c) begin
            m_err = 0;
            m_err4 = 0;
        end
    endtask

    task automatic step(input bit v, input bit b, input bit c);
        in_valid = v;
        in_bit   = b;
        clr_err  = c;
        @(posedge clk);
        model_step(rst_n, v, b, c);
        #1;
        check("match", 32'(match_a), 32'(m_match));
        check("match_valid", 32'(match_valid_a), 32'(m_mv));
        check("locked", 32'(locked_a), 32'(m_locked));
        check("err_cnt", 32'(err_a), 32'(m_err));
        check("locked_w4", 32'(locked_b), 32'(m_locked));
        check("err_cnt_w4", 32'(err_b), 32'(m_err4));
    endtask

    task automatic tx(input bit flip, input bit c);
        step(1'b1, gen_next() ^ flip, c);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        rst_n = 1'b1;
    endtask

    initial begin
        int lock_at, first_mv, mism, cnt, err_before;
        bit ever_locked;

        // Reset state
        do_reset();
        check("reset_match", 32'(match_a), 0);
        check("reset_locked", 32'(locked_a), 0);
        check("reset_err", 32'(err_a), 0);

        // Clean continuous stream from seed 0
        gen_reset();
        lock_at = 0; first_mv = 0;
        for (int i = 1; i <= 1000; i++) begin
            tx(1'b0, 1'b0);
            if (match_valid_a && first_mv == 0) first_mv = i;
            if (locked_a && lock_at == 0) lock_at = i;
        end
        check("first_match_valid_bit", 32'(first_mv), 8);
        check("lock_bit", 32'(lock_at), 23);
        check("clean_err", 32'(err_a), 0);

        // Three isolated flips
        mism = 0;
        for (int i = 0; i < 60; i++) begin
            tx(i % 20 == 0, 1'b0);
            if (match_valid_a && !match_a) mism++;
        end
        check("flip3_err", 32'(err_a), 3);
        check("flip3_mismatch_pulses", 32'(mism), 3);
        check("flip3_locked", 32'(locked_a), 1);

        // Clear, then four consecutive errors drop lock; clean stream relocks
        tx(1'b0, 1'b1);
        check("clr_on_match", 32'(err_a), 0);
        for (int i = 0; i < 4; i++) begin
            tx(1'b1, 1'b0);
            if (i < 3) check("loss_still_locked", 32'(locked_a), 1);
        end
        check("loss_unlocked", 32'(locked_a), 0);
        check("loss_err", 32'(err_a), 4);
        cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            tx(1'b0, 1'b0);
            if (locked_a && cnt == 0) cnt = i;
        end
        check("relock_bits", 32'(cnt), 23);
        check("relock_err_kept", 32'(err_a), 4);

        // err_cnt = 5, then clear on a mismatch cycle
        tx(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) tx(i % 2 == 0, 1'b0);
        check("err_five", 32'(err_a), 5);
        tx(1'b1, 1'b1);
        check("clr_wins_over_mismatch", 32'(err_a), 0);
        check("clr_locked", 32'(locked_a), 1);
        tx(1'b0, 1'b0);

        // Twenty spaced errors: 16-bit counts them, 4-bit saturates
        for (int i = 0; i < 40; i++) tx(i % 2 == 0, 1'b0);
        check("err_twenty", 32'(err_a), 20);
        check("err_w4_saturated", 32'(err_b), 15);

        // Stuck-at-1 input never locks
        do_reset();
        ever_locked = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b1, 1'b0);
            ever_locked |= locked_a;
        end
        check("stuck1_never_locked", 32'(ever_locked), 0);
        check("stuck1_err", 32'(err_a), 0);

        // Random idle gaps: lock point in valid bits unchanged
        do_reset();
        gen_reset();
        cnt = 0;
        for (int i = 1; i <= 60; i++) begin
            int gap;
            gap = $urandom_range(0, 5);
            for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom), 1'b0);
            tx(1'b0, 1'b0);
            if (locked_a && cnt == 0) cnt = i;
        end
        check("gap_lock_bits", 32'(cnt), 23);

        // Reset pulse mid-LOCKED overrides valid and clr
        tx(1'b1, 1'b0);
        rst_n = 1'b0;
        step(1'b1, 1'($urandom), 1'b1);
        check("rst_match", 32'(match_a), 0);
        check("rst_match_valid", 32'(match_valid_a), 0);
        check("rst_locked", 32'(locked_a), 0);
        check("rst_err", 32'(err_a), 0);
        rst_n = 1'b1;

        // Randomized traffic with sporadic flips and gaps against the model
        gen_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) step(1'b0, 1'($urandom), 1'($urandom_range(0, 50) == 0));
            else tx(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 100) == 0));
        end
        err_before = m_err;
        check("random_err_final", 32'(err_a), 32'(err_before));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
